bcd_key_entry: RTL

Parametrised multi-bank BCD digit entry block for the board's push-button panel. Each digit key is synchronised, debounced and edge-detected, then increments or decrements one digit of the active bank, with optional auto-repeat while the key is held. A bank key steps between banks and a clear key zeroes everything. The packed digit vector feeds the seven-segment display driver and downstream arithmetic.

---
 rtl/bcd_key_entry_pkg.sv | 23 ++
 rtl/bcd_key_entry_if.sv | 28 ++
 rtl/bcd_key_entry_debounce.sv | 51 +++++
 rtl/bcd_key_entry.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/bcd_key_entry_pkg.sv
// Shared constants and BCD digit arithmetic for the push-button digit entry block.
package bcd_key_pkg;

  localparam int DIGIT_W = 4;

  localparam int DEF_NUM_DIGITS      = 4;
  localparam int DEF_NUM_BANKS       = 2;
  localparam int DEF_MAX_DIGIT       = 9;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 50000000;
  localparam int DEF_REPEAT_PERIOD   = 20000000;

  function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] digit,
                                                 input logic [DIGIT_W-1:0] max_val);
    return (digit >= max_val) ? {DIGIT_W{1'b0}} : digit + 1'b1;
  endfunction

  function automatic logic [DIGIT_W-1:0] bcd_dec(input logic [DIGIT_W-1:0] digit,
                                                 input logic [DIGIT_W-1:0] max_val);
    return (digit == '0) ? max_val : digit - 1'b1;
  endfunction

endpackage

// File: rtl/bcd_key_entry_if.sv
// Key inputs and digit/bank outputs of the digit entry block.
interface bcd_key_entry_if #(
  parameter int NUM_DIGITS = 4,
  parameter int NUM_BANKS  = 2
);
  import bcd_key_pkg::*;

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic [NUM_DIGITS-1:0]                   key_digit;
  logic                                    key_bank;
  logic                                    key_clear;
  logic                                    key_dec;
  logic [DIGIT_W*NUM_DIGITS*NUM_BANKS-1:0] number;
  logic [BANK_W-1:0]                       bank_sel;
  logic                                    changed;

  modport master (
    output key_digit, key_bank, key_clear, key_dec,
    input  number, bank_sel, changed
  );

  modport slave (
    input  key_digit, key_bank, key_clear, key_dec,
    output number, bank_sel, changed
  );

endinterface

// File: rtl/bcd_key_entry_debounce.sv
// Two-stage synchroniser followed by a stable-sample counter; outputs the
// debounced level and a one-cycle pulse on its rising transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk100mhz,
  input  logic reset,
  input  logic key,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             level_reg;
  logic             rise_reg;

  always_ff @(posedge clk100mhz) begin
    if (!reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
    end else begin
      sync1_reg <= key;
      sync2_reg <= sync1_reg;
      rise_reg  <= 1'b0;
      // Any sample that agrees with the current level restarts the count.
      if (sync2_reg != level_reg) begin
        if (cnt_reg == CNT_LAST) begin
          level_reg <= sync2_reg;
          rise_reg  <= sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;

endmodule

// File: rtl/bcd_key_entry.sv
// Multi-bank BCD digit entry: debounced digit keys step digits of the active
// bank with auto-repeat; bank key cycles banks, clear key zeroes everything.
module bcd_key_entry
  import bcd_key_pkg::*;
#(
  parameter int NUM_DIGITS      = DEF_NUM_DIGITS,
  parameter int NUM_BANKS       = DEF_NUM_BANKS,
  parameter int MAX_DIGIT       = DEF_MAX_DIGIT,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic           clk100mhz,
  input logic           reset,
  bcd_key_entry_if.slave bus
);

  localparam int BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX_DIGIT);

  logic [NUM_DIGITS-1:0] dig_level;
  logic [NUM_DIGITS-1:0] dig_rise;
  logic [NUM_DIGITS-1:0] rpt_fire;
  logic [NUM_DIGITS-1:0] dig_evt;
  logic                  bank_level, bank_rise;
  logic                  clear_level, clear_rise;
  logic                  dec_level, dec_rise;
  logic [BANK_W-1:0]     bank_sel_reg, bank_sel_next;
  logic                  changed_reg;
  logic                  any_evt;
  logic                  unused_deb;

  genvar gi, gb;

  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk100mhz (clk100mhz),
        .reset     (reset),
        .key       (bus.key_digit[gi]),
        .level     (dig_level[gi]),
        .rise      (dig_rise[gi])
      );

      if (REPEAT_DELAY == 0) begin : g_no_rpt
        assign rpt_fire[gi] = 1'b0;
      end else begin : g_rpt
        // cnt_reg==0 means idle; the phase bit switches the threshold from
        // the initial delay to the repeat period, and fires reload the count.
        logic [RPT_W-1:0] cnt_reg;
        logic             phase_reg;
        logic [RPT_W-1:0] limit;

        assign limit        = phase_reg ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY);
        assign rpt_fire[gi] = dig_level[gi] && (cnt_reg != '0) && (cnt_reg == limit);

        always_ff @(posedge clk100mhz) begin
          if (!reset) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
          end else if (dig_rise[gi]) begin
            cnt_reg   <= RPT_W'(1);
            phase_reg <= 1'b0;
          end else if (!dig_level[gi]) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
          end else if (rpt_fire[gi]) begin
            cnt_reg   <= RPT_W'(1);
            phase_reg <= 1'b1;
          end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end
    end
  endgenerate

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_bank (
    .clk100mhz (clk100mhz), .reset (reset), .key (bus.key_bank),
    .level (bank_level), .rise (bank_rise)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clear (
    .clk100mhz (clk100mhz), .reset (reset), .key (bus.key_clear),
    .level (clear_level), .rise (clear_rise)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dec (
    .clk100mhz (clk100mhz), .reset (reset), .key (bus.key_dec),
    .level (dec_level), .rise (dec_rise)
  );

  assign unused_deb = dec_rise ^ bank_level ^ clear_level;
  assign dig_evt    = dig_rise | rpt_fire;
  assign any_evt    = clear_rise | bank_rise | (|dig_evt);

  // Digit cells compare against the current (pre-advance) bank, so a digit
  // event coinciding with a bank event lands in the bank being left.
  generate
    for (gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_cell
        logic [DIGIT_W-1:0] digit_reg;

        always_ff @(posedge clk100mhz) begin
          if (!reset || clear_rise) begin
            digit_reg <= '0;
          end else if (dig_evt[gi] && (bank_sel_reg == BANK_W'(gb))) begin
            digit_reg <= dec_level ? bcd_dec(digit_reg, MAX_D) : bcd_inc(digit_reg, MAX_D);
          end
        end

        assign bus.number[DIGIT_W*(gb*NUM_DIGITS+gi) +: DIGIT_W] = digit_reg;
      end
    end
  endgenerate

  always_comb begin
    bank_sel_next = bank_sel_reg + 1'b1;
    if (bank_sel_reg == BANK_W'(NUM_BANKS - 1)) begin
      bank_sel_next = '0;
    end
  end

  always_ff @(posedge clk100mhz) begin
    if (!reset) begin
      bank_sel_reg <= '0;
      changed_reg  <= 1'b0;
    end else begin
      changed_reg <= any_evt;
      if (clear_rise) begin
        bank_sel_reg <= '0;
      end else if (bank_rise) begin
        bank_sel_reg <= bank_sel_next;
      end
    end
  end

  assign bus.bank_sel = bank_sel_reg;
  assign bus.changed  = changed_reg;

endmodule
